// File: rtl/fifo_pkg.sv
// fifo_pkg: shared link command encodings, FSM state type and default sizes for the replay fifo
package fifo_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int SEQ_W_DEF = 12;
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_ACK  = 2'b01;
  localparam logic [1:0] CMD_NACK = 2'b10;
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_REPLAY = 1'b1;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x 16 storage with one synchronous write port and one combinational read port
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo.sv
// fifo: replay buffer retiring entries on ACK and re-emitting all unacknowledged words on NACK or timeout
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [15:0]              data_in,
  input  logic                     wr,
  input  logic [1:0]               rd,
  input  logic                     tim_out,
  input  logic                     rep,
  output logic [15:0]              data_out,
  output logic                     rdy,
  output logic                     empty,
  output logic                     full,
  output logic [SEQ_W-1:0]         seq,
  output logic [SEQ_W-1:0]         num_packets_to_replay,
  output logic [$clog2(DEPTH)-1:0] replay_index
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, ri_q, ri_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d, npr_q, npr_d;
  logic [15:0] dout_q, dout_d, rdata;
  logic rdy_q, rdy_d;
  state_t state_q, state_d;
  logic wr_ok, ack, nack, emit, idle;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign idle  = state_q == ST_IDLE;
  // a timeout coinciding with ACK wins, so the replay snapshot never races a retire
  assign nack  = en & idle & !empty & (rd == CMD_NACK | tim_out);
  assign ack   = en & idle & !empty & rd == CMD_ACK & !tim_out;
  assign wr_ok = en & wr & !full;
  assign emit  = en & rep & !idle;
  fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(wr_ok), .waddr(wp_q), .wdata(data_in), .raddr(ri_q), .rdata(rdata)
  );
  always_comb begin
    wp_d    = wr_ok ? wp_q + 1'b1 : wp_q;
    rp_d    = ack ? rp_q + 1'b1 : rp_q;
    cnt_d   = (wr_ok & !ack) ? cnt_q + 1'b1 : (ack & !wr_ok) ? cnt_q - 1'b1 : cnt_q;
    seq_d   = wr_ok ? seq_q + 1'b1 : seq_q;
    ri_d    = nack ? rp_q : emit ? ri_q + 1'b1 : ri_q;
    npr_d   = nack ? SEQ_W'(cnt_q) : emit ? npr_q - 1'b1 : npr_q;
    state_d = nack ? ST_REPLAY : (emit & npr_q == SEQ_W'(1)) ? ST_IDLE : state_q;
    dout_d  = emit ? rdata : dout_q;
    rdy_d   = emit;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      ri_q    <= '0;
      npr_q   <= '0;
      state_q <= ST_IDLE;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      ri_q    <= ri_d;
      npr_q   <= npr_d;
      state_q <= state_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
    end
  end
  assign data_out              = dout_q;
  assign rdy                   = rdy_q;
  assign seq                   = seq_q;
  assign num_packets_to_replay = npr_q;
  assign replay_index          = ri_q;
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed self-checking bench for the replay fifo
module tb_fifo;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, wr = 1'b0, tim_out = 1'b0, rep = 1'b0;
  logic [1:0] rd = 2'b00;
  logic [15:0] data_in = '0, data_out;
  logic rdy, empty, full;
  logic [11:0] seq, npr;
  logic [3:0] ri;
  int checks = 0, errors = 0;

  fifo dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .wr(wr), .rd(rd),
    .tim_out(tim_out), .rep(rep), .data_out(data_out), .rdy(rdy),
    .empty(empty), .full(full), .seq(seq), .num_packets_to_replay(npr),
    .replay_index(ri)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_seq"}, 32'(seq), 0);
    chk({tag, "_npr"}, 32'(npr), 0);
    chk({tag, "_ri"}, 32'(ri), 0);
    chk({tag, "_rdy"}, 32'(rdy), 0);
    chk({tag, "_dout"}, 32'(data_out), 0);
  endtask

  initial begin
    #12;
    chk_reset("reset");
    rst = 1'b1;
    en = 1'b1;
    // five consecutive writes
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'(i);
      step();
    end
    wr = 1'b0;
    chk("w5_empty", 32'(empty), 0);
    chk("w5_seq", 32'(seq), 5);
    chk("w5_full", 32'(full), 0);
    // NACK replays all five
    rd = 2'b10;
    step();
    rd = 2'b00;
    chk("nack_npr", 32'(npr), 5);
    chk("nack_ri", 32'(ri), 0);
    chk("nack_rdy", 32'(rdy), 0);
    rep = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rep_rdy", 32'(rdy), 1);
      chk("rep_data", 32'(data_out), 32'(i));
      chk("rep_npr", 32'(npr), 32'(4 - i));
    end
    step();
    chk("rep_done_rdy", 32'(rdy), 0);
    chk("rep_hold_data", 32'(data_out), 4);
    rep = 1'b0;
    // count still 5: four ACKs leave one entry, fifth empties
    rd = 2'b01;
    for (int i = 0; i < 4; i++) step();
    chk("ack4_empty", 32'(empty), 0);
    step();
    chk("ack5_empty", 32'(empty), 1);
    step();
    chk("ack_empty_ignored", 32'(empty), 1);
    rd = 2'b10;
    rep = 1'b1;
    step();
    rd = 2'b00;
    step();
    chk("nack_empty_npr", 32'(npr), 0);
    chk("nack_empty_rdy", 32'(rdy), 0);
    rep = 1'b0;
    // fill to DEPTH
    wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 16'h100 + 16'(i);
      step();
      if (i == 14) chk("fill15_full", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_seq", 32'(seq), 21);
    data_in = 16'hdead;
    step();
    wr = 1'b0;
    chk("drop_seq", 32'(seq), 21);
    chk("drop_full", 32'(full), 1);
    rd = 2'b01;
    step();
    rd = 2'b00;
    chk("ack_full", 32'(full), 0);
    // replay 15 entries across the wrap, with an ignored ACK and an accepted write
    rd = 2'b10;
    step();
    chk("nack2_npr", 32'(npr), 15);
    chk("nack2_ri", 32'(ri), 6);
    rd = 2'b01;
    wr = 1'b1;
    data_in = 16'h300;
    rep = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      rd = 2'b00;
      wr = 1'b0;
      chk("rep2_data", 32'(data_out), 32'(16'h101 + 16'(i)));
      chk("rep2_rdy", 32'(rdy), 1);
    end
    chk("rep2_full", 32'(full), 1);
    chk("rep2_seq", 32'(seq), 22);
    chk("rep2_npr", 32'(npr), 0);
    step();
    rep = 1'b0;
    chk("rep2_idle_rdy", 32'(rdy), 0);
    rd = 2'b01;
    for (int i = 0; i < 15; i++) step();
    chk("ack15_empty", 32'(empty), 0);
    step();
    chk("ack16_empty", 32'(empty), 1);
    rd = 2'b00;
    // three writes, two ACKs, timeout replays the third
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 16'hA1 + 16'(i);
      step();
    end
    wr = 1'b0;
    rd = 2'b01;
    step();
    step();
    rd = 2'b00;
    tim_out = 1'b1;
    step();
    tim_out = 1'b0;
    chk("tim_npr", 32'(npr), 1);
    chk("tim_ri", 32'(ri), 8);
    rep = 1'b1;
    step();
    chk("tim_data", 32'(data_out), 16'hA3);
    chk("tim_rdy", 32'(rdy), 1);
    step();
    rep = 1'b0;
    chk("tim_done_rdy", 32'(rdy), 0);
    // simultaneous write and ACK keep count at 1
    wr = 1'b1;
    rd = 2'b01;
    data_in = 16'hB0;
    step();
    wr = 1'b0;
    chk("wa_empty", 32'(empty), 0);
    chk("wa_seq", 32'(seq), 26);
    step();
    rd = 2'b00;
    chk("wa_ack_empty", 32'(empty), 1);
    // enable low freezes everything
    wr = 1'b1;
    data_in = 16'hC0;
    step();
    data_in = 16'hC1;
    step();
    en = 1'b0;
    rd = 2'b10;
    rep = 1'b1;
    data_in = 16'hC2;
    step();
    chk("en0_seq", 32'(seq), 28);
    chk("en0_npr", 32'(npr), 0);
    chk("en0_rdy", 32'(rdy), 0);
    chk("en0_full", 32'(full), 0);
    en = 1'b1;
    wr = 1'b0;
    rep = 1'b0;
    // async reset mid-replay
    step();
    rd = 2'b00;
    chk("pre_rst_npr", 32'(npr), 2);
    rep = 1'b1;
    step();
    chk("pre_rst_data", 32'(data_out), 16'hC0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("async_rst");
    rep = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rst_empty", 32'(empty), 1);
    chk("post_rst_rdy", 32'(rdy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of 16-bit entries held in the replay buffer (power of two).
REQ-002 Parameter SEQ_W, default 12, width of sequence and replay counters.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 en  input  1  block enable; when 0, no state changes except reset.
REQ-007 data_in  input  16  word to store.
REQ-008 wr  input  1  write request.
REQ-009 rd  input  2  link command: 00 idle, 01 ACK, 10 NACK, 11 reserved (treated as idle).
REQ-010 tim_out  input  1  replay timer expiry, treated as NACK.
REQ-011 rep  input  1  replay advance; one stored word is emitted per cycle while high in REPLAY.
REQ-012 data_out  output  16  registered replayed word.
REQ-013 rdy  output  1  data_out valid, one cycle per emitted word.
REQ-014 empty  output  1  stored count == 0.
REQ-015 full  output  1  stored count == DEPTH.
REQ-016 seq  output  SEQ_W  sequence number assigned to the next accepted write.
REQ-017 num_packets_to_replay  output  SEQ_W  words remaining in the current replay.
REQ-018 replay_index  output  log2(DEPTH)  buffer address of the next word to replay.

Function
REQ-019 Accepted write: en & wr & !full stores data_in at the write pointer, advances the write pointer and count, and increments seq modulo 2^SEQ_W.
REQ-020 Write while full is dropped without changing any state.
REQ-021 ACK (en, rd==01, state IDLE, !empty) retires the oldest entry: read pointer +1, count -1; ACK while empty is ignored.
REQ-022 Simultaneous accepted write and ACK leaves count unchanged and advances both pointers.
REQ-023 FSM states IDLE and REPLAY; reset state IDLE.
REQ-024 IDLE -> REPLAY when en & (rd==10 | tim_out) & !empty: num_packets_to_replay <= count, replay_index <= read pointer.
REQ-025 NACK or tim_out while empty stays in IDLE with no effect.
REQ-026 In REPLAY with en & rep: data_out <= mem[replay_index], rdy <= 1, replay_index +1 (wrapping at DEPTH), num_packets_to_replay -1.
REQ-027 REPLAY -> IDLE on the same edge that emits the last word (num_packets_to_replay reaches 0).
REQ-028 In REPLAY, ACK, NACK and tim_out are ignored; writes are still accepted but are not added to the current replay.
REQ-029 Replay does not retire entries; the read pointer and count change only on ACK.
REQ-030 rdy is 0 in every cycle that emits no word; data_out holds its last value.
REQ-031 Pointers wrap modulo DEPTH; empty and full are decoded combinationally from a log2(DEPTH)+1-bit count.

Reset
REQ-032 rst low asynchronously forces pointers, count, seq, num_packets_to_replay, replay_index, data_out and rdy to 0, state to IDLE, empty=1 and full=0.
REQ-033 Reset during REPLAY aborts the replay; buffer memory contents need not be cleared.

Structure
REQ-034 A shared package holds the rd command encodings (CMD_IDLE, CMD_ACK, CMD_NACK), the FSM state type, and default DEPTH/SEQ_W.
REQ-035 A single sub-module fifo_mem (DEPTH x 16, one synchronous write port, one read port) is natural; control and FSM live in fifo.

Verification
REQ-036 Reset, then write 0x0000..0x0004 on consecutive cycles with en=1 -> empty=0, seq=5, full=0.
REQ-037 After REQ-036, set rd=10 for one cycle -> REPLAY, num_packets_to_replay=5, replay_index=0; then hold rep=1 -> data_out 0,1,2,3,4 with rdy=1 on five consecutive cycles, then return to IDLE with count still 5.
REQ-038 Write DEPTH words -> full=1; one extra write is dropped (seq unchanged); ACK once -> full=0.
REQ-039 Write 3 words, ACK 2, pulse tim_out -> replay of 1 word equal to the third written.
REQ-040 Assert rst low mid-replay -> all outputs return to reset values immediately, without waiting for a clock edge.
REQ-041 en=0 with wr=1 and rd=10 -> no state change.
